// File: rtl/cpu_run_pkg.sv
// Shared types, constants and helpers for the CPU run controller.
package cpu_run_pkg;

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StRelease = 2'd1,
      StRun     = 2'd2,
      StDone    = 2'd3
   } run_state_e;

   // tohost bit that marks an exit request rather than console traffic.
   localparam int unsigned TOHOST_EXIT_BIT = 0;

   // Upper bound on harts; narrower hart vectors are zero-extended to this width.
   localparam int unsigned MAX_HARTS  = 8;
   localparam int unsigned HART_CNT_W = 4;

   // Number of set bits in a hart vector.
   function automatic logic [HART_CNT_W-1:0] popcount(input logic [MAX_HARTS-1:0] vec);
      logic [HART_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(MAX_HARTS); i++) begin
         cnt = cnt + HART_CNT_W'(vec[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/run_sat_counter.sv
// Saturating up-counter with synchronous clear and a variable increment.
module run_sat_counter #(
   parameter int unsigned Width = 32,
   parameter int unsigned IncW  = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [IncW-1:0]  inc_i,
   output logic [Width-1:0] count_o
);

   localparam int unsigned SumW = ((Width > IncW) ? Width : IncW) + 1;
   localparam logic [SumW-1:0] MaxVal = SumW'({Width{1'b1}});

   logic [Width-1:0] count_q, count_d;
   logic [SumW-1:0]  sum;

   // Next count: clear wins, otherwise add and stick at all-ones on overflow.
   always_comb begin
      sum = SumW'(count_q) + SumW'(inc_i);
      if (clr_i) begin
         count_d = '0;
      end else if (!en_i) begin
         count_d = count_q;
      end else if (sum > MaxVal) begin
         count_d = '1;
      end else begin
         count_d = sum[Width-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller: per-hart reset sequencing, cycle/instret accounting and
// tohost exit detection backed by hang and absolute-cycle watchdogs.
module cpu_run_controller
   import cpu_run_pkg::*;
#(
   parameter int unsigned NUM_HARTS       = 1,
   parameter int unsigned XLEN            = 32,
   parameter int unsigned CNT_W           = 32,
   parameter int unsigned RST_HOLD_CYCLES = 4,
   parameter int unsigned STAGGER_CYCLES  = 0,
   parameter int unsigned HANG_CYCLES     = 1000,
   parameter int unsigned MAX_CYCLES      = 100000
) (
   input  logic                 cpu_clk,
   input  logic                 reset,
   input  logic                 restart,
   input  logic [NUM_HARTS-1:0] retire_valid,
   input  logic                 tohost_we,
   input  logic [XLEN-1:0]      tohost_data,
   output logic [NUM_HARTS-1:0] core_reset,
   output logic                 run_active,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [XLEN-1:0]      exit_code,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     instret_count
);

   localparam int unsigned HoldW    = $clog2(RST_HOLD_CYCLES + 2);
   localparam int unsigned StgW     = $clog2(STAGGER_CYCLES + 2);
   localparam int unsigned HangW    = $clog2(HANG_CYCLES + 2);
   localparam int unsigned HoldLast = (RST_HOLD_CYCLES > 0) ? RST_HOLD_CYCLES - 1 : 0;
   localparam int unsigned StgLast  = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;
   localparam int unsigned HangLast = (HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0;
   localparam bit          Staggered = (STAGGER_CYCLES != 0) && (NUM_HARTS > 1);

   run_state_e            state_q;
   logic [HoldW-1:0]      hold_cnt_q;
   logic [StgW-1:0]       stg_cnt_q;
   logic [HangW-1:0]      hang_cnt;
   logic [NUM_HARTS-1:0]  counted_retire;
   logic [NUM_HARTS-1:0]  core_reset_shift;
   logic [HART_CNT_W-1:0] retire_cnt;
   logic [XLEN-1:0]       exit_val;
   logic                  counting, in_run, retired_any, hang_clr;
   logic                  tohost_exit, hang_hit, max_hit;

   // Decode run conditions, counted retirements and exit/watchdog triggers.
   always_comb begin
      counting       = (state_q == StRelease) || (state_q == StRun);
      in_run         = (state_q == StRun);
      counted_retire = retire_valid & ~core_reset;
      retire_cnt     = popcount(MAX_HARTS'(counted_retire));
      retired_any    = |counted_retire;
      hang_clr       = restart || !in_run || retired_any;
      // Held harts are always the contiguous high bits, so a left shift frees the next one.
      core_reset_shift = core_reset << 1;
      exit_val       = tohost_data >> 1;
      tohost_exit    = counting && tohost_we && tohost_data[TOHOST_EXIT_BIT];
      hang_hit       = in_run && !retired_any && (hang_cnt == HangW'(HangLast));
      max_hit        = counting && ((64'(cycle_count) + 64'd1) >= 64'(MAX_CYCLES));
   end

   run_sat_counter #(
      .Width(CNT_W),
      .IncW (1)
   ) u_cycle_cnt (
      .clk_i  (cpu_clk),
      .rst_i  (reset),
      .clr_i  (restart),
      .en_i   (counting),
      .inc_i  (1'b1),
      .count_o(cycle_count)
   );

   run_sat_counter #(
      .Width(CNT_W),
      .IncW (HART_CNT_W)
   ) u_instret_cnt (
      .clk_i  (cpu_clk),
      .rst_i  (reset),
      .clr_i  (restart),
      .en_i   (counting),
      .inc_i  (retire_cnt),
      .count_o(instret_count)
   );

   run_sat_counter #(
      .Width(HangW),
      .IncW (1)
   ) u_hang_cnt (
      .clk_i  (cpu_clk),
      .rst_i  (reset),
      .clr_i  (hang_clr),
      .en_i   (in_run),
      .inc_i  (1'b1),
      .count_o(hang_cnt)
   );

   // Sequencer state and registered status outputs.
   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         state_q    <= StHold;
         hold_cnt_q <= '0;
         stg_cnt_q  <= '0;
         core_reset <= '1;
         run_active <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         exit_code  <= '0;
      end else if (restart) begin
         state_q    <= StHold;
         hold_cnt_q <= '0;
         stg_cnt_q  <= '0;
         core_reset <= '1;
         run_active <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         exit_code  <= '0;
      end else begin
         unique case (state_q)
            StHold: begin
               if (hold_cnt_q == HoldW'(HoldLast)) begin
                  hold_cnt_q <= '0;
                  run_active <= 1'b1;
                  if (Staggered) begin
                     core_reset <= core_reset_shift;
                     state_q    <= StRelease;
                  end else begin
                     core_reset <= '0;
                     state_q    <= StRun;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + HoldW'(1);
               end
            end
            StRelease, StRun: begin
               if (tohost_exit) begin
                  state_q    <= StDone;
                  core_reset <= '1;
                  run_active <= 1'b0;
                  done       <= 1'b1;
                  exit_code  <= exit_val;
                  pass       <= (exit_val == '0);
                  fail       <= (exit_val != '0);
               end else if (hang_hit || max_hit) begin
                  state_q    <= StDone;
                  core_reset <= '1;
                  run_active <= 1'b0;
                  done       <= 1'b1;
                  timeout    <= 1'b1;
               end else if (state_q == StRelease) begin
                  if (stg_cnt_q == StgW'(StgLast)) begin
                     stg_cnt_q  <= '0;
                     core_reset <= core_reset_shift;
                     if (core_reset_shift == '0) begin
                        state_q <= StRun;
                     end
                  end else begin
                     stg_cnt_q <= stg_cnt_q + StgW'(1);
                  end
               end
            end
            StDone: begin
               // Frozen until restart or reset.
            end
            default: state_q <= StHold;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: scoreboard of expected status snapshots.
module tb_cpu_run_controller;

   logic cpu_clk = 1'b0;
   logic reset   = 1'b1;

   always #5 cpu_clk = ~cpu_clk;

   // DUT A: one hart, short hang and cycle limits.
   logic        a_restart = 1'b0;
   logic [0:0]  a_retire  = 1'b0;
   logic        a_we      = 1'b0;
   logic [31:0] a_data    = '0;
   logic [0:0]  a_core_reset;
   logic        a_run_active, a_done, a_pass, a_fail, a_timeout;
   logic [31:0] a_exit_code, a_cycle_count, a_instret_count;

   // DUT B: three staggered harts, 4-bit counters.
   logic        b_restart = 1'b0;
   logic [2:0]  b_retire  = '0;
   logic        b_we      = 1'b0;
   logic [31:0] b_data    = '0;
   logic [2:0]  b_core_reset;
   logic        b_run_active, b_done, b_pass, b_fail, b_timeout;
   logic [31:0] b_exit_code;
   logic [3:0]  b_cycle_count, b_instret_count;

   cpu_run_controller #(
      .NUM_HARTS(1), .XLEN(32), .CNT_W(32), .RST_HOLD_CYCLES(4),
      .STAGGER_CYCLES(0), .HANG_CYCLES(10), .MAX_CYCLES(30)
   ) u_dut_a (
      .cpu_clk(cpu_clk), .reset(reset), .restart(a_restart), .retire_valid(a_retire),
      .tohost_we(a_we), .tohost_data(a_data), .core_reset(a_core_reset),
      .run_active(a_run_active), .done(a_done), .pass(a_pass), .fail(a_fail),
      .timeout(a_timeout), .exit_code(a_exit_code), .cycle_count(a_cycle_count),
      .instret_count(a_instret_count)
   );

   cpu_run_controller #(
      .NUM_HARTS(3), .XLEN(32), .CNT_W(4), .RST_HOLD_CYCLES(4),
      .STAGGER_CYCLES(2), .HANG_CYCLES(1000), .MAX_CYCLES(100000)
   ) u_dut_b (
      .cpu_clk(cpu_clk), .reset(reset), .restart(b_restart), .retire_valid(b_retire),
      .tohost_we(b_we), .tohost_data(b_data), .core_reset(b_core_reset),
      .run_active(b_run_active), .done(b_done), .pass(b_pass), .fail(b_fail),
      .timeout(b_timeout), .exit_code(b_exit_code), .cycle_count(b_cycle_count),
      .instret_count(b_instret_count)
   );

   typedef struct packed {
      logic        core_reset;
      logic        run_active;
      logic        done;
      logic        pass;
      logic        fail;
      logic        timeout;
      logic [31:0] exit_code;
      logic [31:0] cycle_count;
      logic [31:0] instret_count;
   } a_obs_t;

   typedef struct packed {
      logic [2:0] core_reset;
      logic       run_active;
      logic       done;
      logic [3:0] cycle_count;
      logic [3:0] instret_count;
   } b_obs_t;

   a_obs_t obs_a;
   b_obs_t obs_b;
   a_obs_t sb_a[$];
   b_obs_t sb_b[$];
   int     checks = 0;
   int     errors = 0;

   assign obs_a = {a_core_reset, a_run_active, a_done, a_pass, a_fail, a_timeout,
                   a_exit_code, a_cycle_count, a_instret_count};
   assign obs_b = {b_core_reset, b_run_active, b_done, b_cycle_count, b_instret_count};

   function automatic a_obs_t mk_a(bit cr, bit ra, bit dn, bit ps, bit fl, bit to,
                                   int unsigned ec, int unsigned cc, int unsigned ic);
      a_obs_t r;
      r.core_reset    = cr;
      r.run_active    = ra;
      r.done          = dn;
      r.pass          = ps;
      r.fail          = fl;
      r.timeout       = to;
      r.exit_code     = ec;
      r.cycle_count   = cc;
      r.instret_count = ic;
      return r;
   endfunction

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   // Hold reset for two edges, release just after an edge.
   task automatic do_reset();
      reset     = 1'b1;
      a_restart = 1'b0;
      a_we      = 1'b0;
      a_data    = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_to_run();
      do_reset();
      repeat (4) step();
   endtask

   task automatic test_reset();
      a_obs_t e;
      a_retire = 1'b0;
      do_reset();
      reset = 1'b1;
      #1;
      sb_a.push_back(mk_a(1, 0, 0, 0, 0, 0, 0, 0, 0));
      e = sb_a.pop_front();
      checks++;
      if (obs_a !== e) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", obs_a, e);
      end
      step();
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         sb_a.push_back(mk_a(k < 4, k >= 4, 0, 0, 0, 0, 0, (k > 4) ? k - 4 : 0, 0));
         step();
         e = sb_a.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %h expected %h", k, obs_a, e);
         end
      end
   endtask

   task automatic test_tohost();
      a_obs_t e;
      a_retire = 1'b1;
      run_to_run();
      // Console write: no exit.
      a_we = 1'b1; a_data = 32'h4;
      sb_a.push_back(mk_a(0, 1, 0, 0, 0, 0, 0, 1, 1));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL tohost_console: got %h expected %h", obs_a, e);
      end
      a_data = 32'h1;
      sb_a.push_back(mk_a(1, 0, 1, 1, 0, 0, 0, 2, 2));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL tohost_pass: got %h expected %h", obs_a, e);
      end
      // Writes in DONE are ignored and everything stays frozen.
      a_data = 32'h7;
      sb_a.push_back(mk_a(1, 0, 1, 1, 0, 0, 0, 2, 2));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL done_frozen: got %h expected %h", obs_a, e);
      end
      a_we = 1'b0; a_restart = 1'b1;
      sb_a.push_back(mk_a(1, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL restart_clear: got %h expected %h", obs_a, e);
      end
      // Exit writes during HOLD are ignored.
      a_restart = 1'b0; a_we = 1'b1; a_data = 32'h1;
      sb_a.push_back(mk_a(0, 1, 0, 0, 0, 0, 0, 0, 0));
      repeat (4) step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL hold_ignores_tohost: got %h expected %h", obs_a, e);
      end
      a_data = 32'h7;
      sb_a.push_back(mk_a(1, 0, 1, 0, 1, 0, 3, 1, 1));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL tohost_fail: got %h expected %h", obs_a, e);
      end
      a_data = 32'h1;
      sb_a.push_back(mk_a(1, 0, 1, 0, 1, 0, 3, 1, 1));
      step();
      a_we = 1'b0;
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL fail_sticky: got %h expected %h", obs_a, e);
      end
   endtask

   task automatic test_hang();
      a_obs_t e;
      bit     dn;
      a_retire = 1'b0;
      run_to_run();
      for (int k = 1; k <= 20; k++) begin
         a_retire = (k == 9);
         dn = (k >= 19);
         sb_a.push_back(mk_a(dn, !dn, dn, 0, 0, dn, 0, dn ? 19 : k, (k >= 9) ? 1 : 0));
         step();
         e = sb_a.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL hang_window edge %0d: got %h expected %h", k, obs_a, e);
         end
      end
      a_retire = 1'b0;
   endtask

   task automatic test_priority();
      a_obs_t e;
      a_retire = 1'b1;
      run_to_run();
      for (int k = 1; k <= 29; k++) begin
         sb_a.push_back(mk_a(0, 1, 0, 0, 0, 0, 0, k, k));
         step();
         e = sb_a.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL run_count edge %0d: got %h expected %h", k, obs_a, e);
         end
      end
      // Exit and MAX_CYCLES hit together: exit wins.
      a_we = 1'b1; a_data = 32'h1;
      sb_a.push_back(mk_a(1, 0, 1, 1, 0, 0, 0, 30, 30));
      step();
      a_we = 1'b0;
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL exit_beats_max: got %h expected %h", obs_a, e);
      end
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
      repeat (33) step();
      sb_a.push_back(mk_a(0, 1, 0, 0, 0, 0, 0, 29, 29));
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL rerun_count: got %h expected %h", obs_a, e);
      end
      // Restart beats both exit and MAX_CYCLES.
      a_we = 1'b1; a_data = 32'h1; a_restart = 1'b1;
      sb_a.push_back(mk_a(1, 0, 0, 0, 0, 0, 0, 0, 0));
      step();
      a_we = 1'b0; a_restart = 1'b0;
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL restart_beats_exit: got %h expected %h", obs_a, e);
      end
      repeat (33) step();
      sb_a.push_back(mk_a(1, 0, 1, 0, 0, 1, 0, 30, 30));
      step();
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL max_cycles_timeout: got %h expected %h", obs_a, e);
      end
   endtask

   task automatic test_async_reset();
      a_obs_t e;
      a_retire = 1'b1;
      run_to_run();
      repeat (3) step();
      sb_a.push_back(mk_a(0, 1, 0, 0, 0, 0, 0, 3, 3));
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL pre_pulse: got %h expected %h", obs_a, e);
      end
      #2 reset = 1'b1;
      #1;
      sb_a.push_back(mk_a(1, 0, 0, 0, 0, 0, 0, 0, 0));
      e = sb_a.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL async_reset: got %h expected %h", obs_a, e);
      end
      #1 reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         sb_a.push_back(mk_a(k < 4, k >= 4, 0, 0, 0, 0, 0, (k > 4) ? k - 4 : 0,
                             (k > 4) ? k - 4 : 0));
         step();
         e = sb_a.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL rerun_after_pulse edge %0d: got %h expected %h", k, obs_a, e);
         end
      end
   endtask

   task automatic test_stagger();
      b_obs_t e;
      int     ic;
      b_retire = 3'b111;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         e.core_reset = (k < 4) ? 3'b111 : (k < 6) ? 3'b110 : (k < 8) ? 3'b100 : 3'b000;
         e.run_active = (k >= 4);
         e.done       = 1'b0;
         e.cycle_count = (k <= 4) ? 4'd0 : (k - 4 > 15) ? 4'd15 : 4'(k - 4);
         if (k <= 4)      ic = 0;
         else if (k == 5) ic = 1;
         else if (k == 6) ic = 2;
         else if (k == 7) ic = 4;
         else             ic = (6 + 3 * (k - 8) > 15) ? 15 : 6 + 3 * (k - 8);
         e.instret_count = 4'(ic);
         sb_b.push_back(e);
         step();
         e = sb_b.pop_front(); checks++;
         if (obs_b !== e) begin
            errors++; $display("FAIL stagger edge %0d: got %h expected %h", k, obs_b, e);
         end
      end
      b_retire = '0;
   endtask

   initial begin
      test_reset();
      test_tohost();
      test_hang();
      test_priority();
      test_async_reset();
      test_stagger();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run controller for the RISC-V base-ISA CPU simulation and FPGA bring-up environment.
- Replaces fixed-delay reset and fixed-time finish with three functions:
  - a parametrised per-hart reset sequencer;
  - instruction and cycle accounting;
  - a tohost-based pass/fail exit detector backed by hang and absolute-cycle watchdogs.
- Sits beside one or more RISC_V_Base_data_path instances and drives their reset inputs.

Parameters:
- NUM_HARTS, 1, number of cores/harts controlled (1..8).
- XLEN, 32, width of tohost data.
- CNT_W, 32, width of cycle and instret counters.
- RST_HOLD_CYCLES, 4, cycles all harts are held in reset after reset deasserts or after restart (>=1).
- STAGGER_CYCLES, 0, cycles between successive hart releases (0 = simultaneous).
- HANG_CYCLES, 1000, consecutive RUN cycles with no retirement that cause timeout.
- MAX_CYCLES, 100000, absolute cycle_count limit that causes timeout.

Ports:
- cpu_clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- restart  in  1  synchronous request to re-run the full sequence.
- retire_valid  in  NUM_HARTS  per-hart instruction-retired strobe.
- tohost_we  in  1  store to the tohost address this cycle.
- tohost_data  in  XLEN  store data.
- core_reset  out  NUM_HARTS  per-hart reset (1 = held).
- run_active  out  1  at least one hart released and run not finished.
- done  out  1  run finished (sticky).
- pass  out  1  exit with code 0.
- fail  out  1  exit with nonzero code.
- timeout  out  1  a watchdog fired.
- exit_code  out  XLEN  tohost_data >> 1 at exit.
- cycle_count  out  CNT_W  cycles since first hart release, saturating.
- instret_count  out  CNT_W  total retirements across released harts, saturating.

Behaviour:
- Interface: one clock, cpu_clk; reset is asynchronous and active-high, port named reset.
- Reset values:
  - core_reset all 1.
  - All other outputs 0.
  - State HOLD; internal hold, stagger and hang counters 0.
- States: HOLD, RELEASE, RUN, DONE.
- HOLD:
  - core_reset all 1; counters frozen at 0.
  - After RST_HOLD_CYCLES rising edges, core_reset[0] falls.
  - Next state is RUN if STAGGER_CYCLES=0 or NUM_HARTS=1; otherwise RELEASE.
  - If STAGGER_CYCLES=0, all core_reset bits fall on the same edge.
- RELEASE:
  - core_reset[k] falls STAGGER_CYCLES edges after core_reset[k-1].
  - Enter RUN on the edge that releases the last hart.
- run_active = 1 in RELEASE and RUN.
- cycle_count increments by 1 on every edge in RELEASE/RUN and saturates at all-ones.
- instret_count adds popcount(retire_valid & ~core_reset) each cycle in RELEASE/RUN and saturates. Retire strobes from harts still in reset are ignored.
- Hang counter (RUN only):
  - clears on any counted retirement, otherwise increments;
  - reaching HANG_CYCLES -> DONE, timeout=1.
- cycle_count reaching MAX_CYCLES -> DONE, timeout=1.
- tohost handling (RELEASE/RUN only):
  - tohost_we with tohost_data[0]=1 -> DONE next edge, exit_code = tohost_data >> 1;
  - pass = (exit_code==0), fail = !pass.
  - tohost_we with tohost_data[0]=0 is ignored (console traffic).
  - tohost_we in HOLD or DONE is ignored.
- Same-cycle priority: tohost exit beats timeout. Only one of pass/fail/timeout is ever 1.
- DONE:
  - done=1; status and counters frozen; run_active=0;
  - core_reset reasserted to all 1 on the entry edge to freeze the cores.
- restart=1 in any state:
  - next edge -> HOLD;
  - all status, counters and exit_code cleared; core_reset all 1.
  - restart takes priority over a tohost exit or timeout in the same cycle.
- reset asserted mid-run: immediate return to reset values regardless of the clock; dominates restart.

Decomposition:
- Package cpu_run_pkg holds:
  - state enum run_state_e (HOLD, RELEASE, RUN, DONE);
  - TOHOST_EXIT_BIT = 0;
  - a popcount function for NUM_HARTS-wide vectors.
- One sub-module, run_sat_counter (width param; clear, inc amount, saturate), instantiated for cycle_count, instret_count and the hang counter.

Test Plan:
- Reset release, NUM_HARTS=1, RST_HOLD_CYCLES=4: deassert reset -> core_reset falls on the 4th edge; run_active=1 and cycle_count=1 on the following edge.
- Stagger, NUM_HARTS=3, STAGGER_CYCLES=2: -> core_reset releases at edges 4, 6 and 8; RUN entered at edge 8; instret ignores retire strobes from held harts.
- tohost exit: write 0x1 -> pass=1, exit_code=0. Write 0x7 after restart -> fail=1, exit_code=3. Write 0x4 -> no effect.
- Hang watchdog, HANG_CYCLES=10: no retire for 10 RUN cycles -> timeout=1, done=1, core_reset all 1. A retire at cycle 9 restarts the window.
- Priority: tohost 0x1 and a MAX_CYCLES hit on the same cycle -> pass=1, timeout=0. restart on that same cycle -> HOLD with all status 0.
- Mid-run async reset pulse between clock edges -> outputs return to reset values immediately; sequence reruns from HOLD; instret_count saturates when forced near all-ones with CNT_W=4.
